// File: rtl/requant_scheduler.sv
// requant_scheduler: per-channel requantization sequencer with credit-protected output FIFO
module requant_scheduler #(
  parameter int NUM_CH     = 16,
  parameter int CH_W       = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_addr,
  input  logic [31:0]     cfg_multiplier,
  input  logic [7:0]      cfg_shift,
  input  logic            start,
  input  logic [15:0]     num_elems,
  input  logic [CH_W:0]   num_channels,
  input  logic [7:0]      zero_point,
  input  logic [7:0]      act_min,
  input  logic [7:0]      act_max,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  output logic            qm_input_valid,
  output logic [31:0]     qm_x,
  output logic [31:0]     qm_multiplier,
  output logic [31:0]     qm_shift,
  input  logic            qm_output_valid,
  input  logic [7:0]      qm_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic            busy,
  output logic            done
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t          r_state, w_next;
  logic [31:0]     r_mult  [NUM_CH];
  logic [7:0]      r_shift [NUM_CH];
  logic [7:0]      r_mem   [FIFO_DEPTH];
  logic [CH_W-1:0] r_ch;
  logic [CH_W:0]   r_nch;
  logic [15:0]     r_rem;
  logic [7:0]      r_zp, r_min, r_max;
  logic [CW-1:0]   r_infl, r_cnt, w_infl_n, w_cnt_n;
  logic [AW-1:0]   r_wr, r_rd;
  logic            r_qv;
  logic [31:0]     r_qx, r_qm, r_qs;
  logic            w_hs, w_ret, w_pop, w_ch_last;
  logic [8:0]      w_sum;
  logic [7:0]      w_clamp;
  // credit = results still in the multiplier plus results already buffered
  assign in_ready  = r_state == RUN && r_rem != 16'd0 &&
                     ({1'b0, r_infl} + {1'b0, r_cnt}) < (CW + 1)'(FIFO_DEPTH);
  assign w_hs      = in_valid && in_ready;
  assign w_ret     = qm_output_valid && r_state != IDLE;
  assign w_pop     = out_valid && out_ready;
  assign w_infl_n  = r_infl + CW'(w_hs) - CW'(w_ret && r_infl != '0);
  assign w_cnt_n   = r_cnt + CW'(w_ret) - CW'(w_pop);
  assign w_ch_last = {1'b0, r_ch} == r_nch - (CH_W + 1)'(1);
  assign w_sum     = {qm_result[7], qm_result} + {r_zp[7], r_zp};
  assign w_clamp   = $signed(w_sum) < $signed({r_min[7], r_min}) ? r_min :
                     $signed(w_sum) > $signed({r_max[7], r_max}) ? r_max : w_sum[7:0];
  assign out_valid      = r_cnt != '0;
  assign out_data       = out_valid ? r_mem[r_rd] : 8'd0;
  assign qm_input_valid = r_qv;
  assign qm_x           = r_qx;
  assign qm_multiplier  = r_qm;
  assign qm_shift       = r_qs;
  assign busy           = r_state != IDLE;
  assign done           = r_state == DONE;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  w_next = start ? (num_elems == 16'd0 ? DONE : RUN) : IDLE;
      RUN:   w_next = (w_hs && r_rem == 16'd1) ? DRAIN : RUN;
      DRAIN: w_next = (w_infl_n == '0 && w_cnt_n == '0) ? DONE : DRAIN;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_nch   <= '0;
      r_rem   <= '0;
      r_zp    <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_infl  <= '0;
      r_cnt   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_qv    <= 1'b0;
      r_qx    <= '0;
      r_qm    <= '0;
      r_qs    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_mult[i]  <= '0;
        r_shift[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_infl  <= w_infl_n;
      r_cnt   <= w_cnt_n;
      r_qv    <= w_hs;
      if (r_state == IDLE && cfg_we) begin
        r_mult[cfg_addr]  <= cfg_multiplier;
        r_shift[cfg_addr] <= cfg_shift;
      end
      if (r_state == IDLE && start) begin
        r_ch  <= '0;
        r_rem <= num_elems;
        r_nch <= num_channels;
        r_zp  <= zero_point;
        r_min <= act_min;
        r_max <= act_max;
      end
      if (w_hs) begin
        r_qx  <= in_data;
        r_qm  <= r_mult[r_ch];
        r_qs  <= {{24{r_shift[r_ch][7]}}, r_shift[r_ch]};
        r_ch  <= w_ch_last ? '0 : r_ch + 1'b1;
        r_rem <= r_rem - 16'd1;
      end
      if (w_ret) r_wr <= r_wr == AW'(FIFO_DEPTH - 1) ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd == AW'(FIFO_DEPTH - 1) ? '0 : r_rd + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_ret) r_mem[r_wr] <= w_clamp;
  end
  always_ff @(posedge clk) begin
    if (!rst) assert (!(w_ret && !w_pop && r_cnt == CW'(FIFO_DEPTH)));
  end
endmodule

// File: tb/tb_requant_scheduler.sv
// tb_requant_scheduler: randomized bench with a behavioural multiplier and per-tensor expected-output model
module tb_requant_scheduler;
  localparam int NCH = 16, CHW = 4, DEPTH = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_we = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [CHW-1:0] cfg_addr = '0;
  logic [31:0] cfg_multiplier = '0, in_data = '0;
  logic [7:0] cfg_shift = '0, zero_point = '0, act_min = '0, act_max = '0;
  logic [15:0] num_elems = '0;
  logic [CHW:0] num_channels = '0;
  logic in_ready, qm_input_valid, qm_output_valid, out_valid, busy, done;
  logic [31:0] qm_x, qm_multiplier, qm_shift;
  logic [7:0] qm_result, out_data;
  logic [2:0] mv;
  logic [7:0] mr [3];
  int n_chk = 0, n_bad = 0;
  int issues_tot = 0, done_tot = 0, ov_tot = 0;
  int t_mult [NCH];
  int t_shift [NCH];
  int din [$];
  int expq [$];
  always #5 clk = ~clk;
  requant_scheduler #(.NUM_CH(NCH), .CH_W(CHW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_multiplier(cfg_multiplier), .cfg_shift(cfg_shift), .start(start),
    .num_elems(num_elems), .num_channels(num_channels), .zero_point(zero_point),
    .act_min(act_min), .act_max(act_max), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .qm_input_valid(qm_input_valid), .qm_x(qm_x),
    .qm_multiplier(qm_multiplier), .qm_shift(qm_shift),
    .qm_output_valid(qm_output_valid), .qm_result(qm_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done));
  function automatic int mbqm(int x, int m, int s);
    longint a, ab, nudge;
    int hm, left, right, mask, rem, thr;
    left  = s > 0 ? s : 0;
    right = s > 0 ? 0 : -s;
    a     = longint'(x) * (longint'(1) << left);
    ab    = a * longint'(m);
    nudge = ab >= 0 ? (longint'(1) << 30) : (longint'(1) - (longint'(1) << 30));
    hm    = int'((ab + nudge) / (longint'(1) << 31));
    mask  = (1 << right) - 1;
    rem   = hm & mask;
    thr   = (mask >>> 1) + (hm < 0 ? 1 : 0);
    return (hm >>> right) + (rem > thr ? 1 : 0);
  endfunction
  function automatic int sat8(int v);
    return v < -128 ? -128 : v > 127 ? 127 : v;
  endfunction
  function automatic int ref_out(int x, int ch, int zp, int amin, int amax);
    int s;
    s = sat8(mbqm(x, t_mult[ch], t_shift[ch])) + zp;
    return s < amin ? amin : s > amax ? amax : s;
  endfunction
  // three-stage multiplier stand-in, cleared by the shared reset
  always @(posedge clk) begin
    if (rst) mv <= '0;
    else begin
      mv    <= {mv[1:0], qm_input_valid};
      mr[0] <= 8'(sat8(mbqm($signed(qm_x), $signed(qm_multiplier), $signed(qm_shift))));
      mr[1] <= mr[0];
      mr[2] <= mr[1];
    end
  end
  assign qm_output_valid = mv[2];
  assign qm_result       = mr[2];
  always @(negedge clk) begin
    if (qm_input_valid) issues_tot++;
    if (done) done_tot++;
    if (out_valid) ov_tot++;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cfg(input int a, input int m, input int s);
    cfg_we = 1'b1; cfg_addr = CHW'(a); cfg_multiplier = 32'(m); cfg_shift = 8'(s);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    t_mult[a] = m; t_shift[a] = s;
  endtask
  task automatic go(input int n, input int nch, input int zp, input int amin, input int amax);
    num_elems = 16'(n); num_channels = (CHW + 1)'(nch);
    zero_point = 8'(zp); act_min = 8'(amin); act_max = 8'(amax);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  // rmode: 0 random out_ready, 1 always ready, 2 stalled for 40 cycles then ready
  task automatic run(input int nch, input int zp, input int amin, input int amax,
                     input int rmode, input bit lock_try);
    int n, idx, k, cyc, extra, outst, maxo, is0, dn0;
    bit seen;
    n = din.size(); idx = 0; k = 0; cyc = 0; extra = 0; outst = 0; maxo = 0; seen = 0;
    is0 = issues_tot; dn0 = done_tot;
    expq = {};
    for (int i = 0; i < n; i++) expq.push_back(ref_out(din[i], i % nch, zp, amin, amax));
    go(n, nch, zp, amin, amax);
    chk("busy_after_start", int'(busy), 1);
    while (cyc < 3000 && extra < 3) begin
      in_valid  = idx < n && (rmode != 0 || $urandom_range(0, 3) != 0);
      in_data   = idx < n ? din[idx] : 0;
      out_ready = rmode == 0 ? 1'($urandom_range(0, 1)) : rmode == 2 ? (cyc >= 40) : 1'b1;
      cfg_we = lock_try && cyc == 2; cfg_addr = '0; cfg_multiplier = '0; cfg_shift = '0;
      @(negedge clk);
      if (in_valid && in_ready) begin idx++; outst++; end
      if (out_valid && out_ready) begin
        chk("out_data", int'($signed(out_data)), k < n ? expq[k] : -999);
        k++; outst--;
      end
      if (outst > maxo) maxo = outst;
      if (rmode == 2 && cyc == 39) chk("bp_accepted", idx, DEPTH);
      if (done) seen = 1;
      if (seen) extra++;
      @(posedge clk); #1;
      cyc++;
    end
    cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    if (cyc >= 3000) chk("timeout", cyc, 0);
    chk("out_count", k, n);
    chk("issues", issues_tot - is0, n);
    chk("done_pulses", done_tot - dn0, 1);
    chk("credit_bound", int'(maxo <= DEPTH), 1);
    chk("busy_end", int'(busy), 0);
  endtask
  initial begin
    int is0, dn0, ov0, idx, nn, nc;
    for (int i = 0; i < NCH; i++) begin t_mult[i] = 0; t_shift[i] = 0; end
    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_qm_valid", int'(qm_input_valid), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_qm_x", qm_x, 0);
    chk("rst_qm_mult", qm_multiplier, 0);
    chk("rst_qm_shift", qm_shift, 0);
    chk("rst_out_data", int'(out_data), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    cfg(0, 32'h40000000, 0);
    cfg(1, 32'h40000000, 1);
    din = {100, 100, -40, -40};
    run(2, 10, -128, 127, 1, 0);
    run(2, 10, -20, 100, 1, 0);
    run(2, 10, -128, 127, 1, 1);
    cfg(0, 0, 0);
    run(2, 10, -128, 127, 1, 0);
    cfg(0, 32'h40000000, 0);
    din = {};
    for (int i = 0; i < 20; i++) din.push_back($urandom_range(0, 600) - 300);
    run(2, -5, -128, 127, 2, 0);
    is0 = issues_tot; dn0 = done_tot;
    go(0, 3, 0, -128, 127);
    repeat (4) @(posedge clk); #1;
    chk("zero_done", done_tot - dn0, 1);
    chk("zero_issues", issues_tot - is0, 0);
    for (int t = 0; t < 6; t++) begin
      for (int c = 0; c < NCH; c++)
        cfg(c, int'($urandom_range(32'h7fffffff, 32'h40000000)), int'($urandom_range(0, 8)) - 4);
      nn = $urandom_range(1, 40); nc = $urandom_range(1, NCH);
      din = {};
      for (int i = 0; i < nn; i++) din.push_back($urandom_range(0, 6000) - 3000);
      run(nc, int'($urandom_range(0, 60)) - 30, -100, 90, 0, 0);
    end
    din = {5, 6, 7};
    go(3, 2, 0, -128, 127);
    in_valid = 1'b1; out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 10 && idx < 3; c++) begin
      in_data = din[idx];
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mid_busy", int'(busy), 1);
    chk("mid_accepted", idx, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_in_ready", int'(in_ready), 0);
    ov0 = ov_tot;
    repeat (20) @(posedge clk); #1;
    chk("mrst_stale", ov_tot - ov0, 0);
    for (int i = 0; i < NCH; i++) begin t_mult[i] = 0; t_shift[i] = 0; end
    din = {1000, -1000, 50, 7, -3};
    run(3, 7, -128, 127, 1, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/requant_scheduler.md
# requant_scheduler

Sequencing and configuration controller for the `MultiplyByQuantizedMultiplier` requantization pipeline. It accepts a stream of int32 accumulators for one tensor and applies per-channel quantization from an internal table:

- channel index is innermost and auto-incrementing;
- each element is issued to the multiplier with that channel's multiplier/shift;
- the int8 result gets the output zero point added, then is clamped to the activation range;
- results are buffered in a credit-protected FIFO so downstream backpressure never stalls the non-stallable multiplier pipeline.

## Interface

Parameters:
- `NUM_CH`, 16: per-channel table entries.
- `CH_W`, 4: channel index width (clog2 `NUM_CH`).
- `FIFO_DEPTH`, 8: output FIFO entries; must be ≥ multiplier latency + 1.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high. Shared with the multiplier instance.
- `cfg_we` in 1, `cfg_addr` in `CH_W`: table write strobe and entry index.
- `cfg_multiplier` in 32, `cfg_shift` in 8 (signed): table write data.
- `start` in 1: begin a tensor; sampled only in IDLE.
- `num_elems` in 16: element count, sampled at `start`.
- `num_channels` in `CH_W`+1: channels, 1..`NUM_CH`, sampled at `start`.
- `zero_point`, `act_min`, `act_max` in 8 each (signed): sampled at `start`.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 32 (signed): accumulator stream.
- `qm_input_valid` out 1, `qm_x` out 32, `qm_multiplier` out 32, `qm_shift` out 32: to multiplier.
- `qm_output_valid` in 1, `qm_result` in 8 (signed): from multiplier.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 8 (signed): int8 result stream.
- `busy` out 1, `done` out 1.

## Operation

States: IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - `start` → latch parameters, clear `ch_cnt`, load `elem_rem`=`num_elems`.
  - Next state is RUN, or DONE if `num_elems`==0.
  - `cfg_we` writes the table only in IDLE; it is ignored in every other state.
- **RUN:**
  - `in_ready` = (`elem_rem`≠0) && (`inflight` + `fifo_count` < `FIFO_DEPTH`).
  - On handshake, register the issue: `qm_x`=`in_data`, `qm_multiplier`=table[`ch_cnt`].mult, `qm_shift`=sign-extended table[`ch_cnt`].shift, and pulse `qm_input_valid`.
  - `ch_cnt` wraps from `num_channels`−1 to 0.
  - `elem_rem`−1; RUN → DRAIN when `elem_rem` reaches 0.
- **DRAIN:** `in_ready`=0. DRAIN → DONE when `inflight`==0 and `fifo_count`==0.
- **DONE:** `done`=1 for exactly one cycle → IDLE.
- `busy`=1 in RUN, DRAIN and DONE.
- `inflight` counter: +1 at issue handshake, −1 at `qm_output_valid`. Simultaneous inc and dec leaves it unchanged. It never exceeds `FIFO_DEPTH`.
- **FIFO push** on `qm_output_valid` (not in IDLE):
  - `sum` = 9-bit signed `qm_result` + `zero_point`.
  - push value = `act_min` if `sum` < `act_min`; `act_max` if `sum` > `act_max`; else `sum`[7:0].
- **FIFO pop** on `out_valid` && `out_ready`. First-word-fall-through: `out_valid` = `fifo_count`≠0. Simultaneous push and pop on a full or empty FIFO is legal.
- Any `qm_output_valid` in IDLE is ignored.
- Credit guarantees no push into a full FIFO. Overflow is a design error; flag it with an assertion in simulation.

## Timing

- Reset values:
  - state IDLE;
  - all counters 0;
  - `in_ready`, `qm_input_valid`, `out_valid`, `busy`, `done` = 0;
  - `qm_x`, `qm_multiplier`, `qm_shift`, `out_data` = 0;
  - table entries multiplier 0, shift 0.
- Input handshake at edge T → `qm_input_valid` high during cycle T+1 → `qm_output_valid` at T+1+L (L = multiplier latency) → FIFO write at that edge → `out_valid` earliest at T+2+L.
- Throughput: 1 element/cycle while `out_ready`=1.
- `start` at edge S → `busy`=1 from S+1.
- `done` is asserted the cycle after the final pop empties the FIFO with `inflight`==0.
- `start` while `busy` is ignored.
- Reset mid-tensor: all state returns to reset values at the next edge. The multiplier is cleared by the same `rst`. The table is re-cleared.

## Test plan

- Channel wrap:
  - Setup: ch0 = (0x40000000, 0), ch1 = (0x40000000, 1); `num_channels`=2, `num_elems`=4, `zero_point`=10, range [−128,127].
  - Stimulus: inputs 100, 100, −40, −40.
  - Expect outputs 60, 110, −10, −30, then one `done` pulse.
- Clamp: same setup with `act_max`=100, `act_min`=−20; inputs 100, 100, −40, −40 → 60, 100, −10, −20.
- Backpressure:
  - Stimulus: `out_ready`=0 with 20 elements pending.
  - Expect `in_ready` to drop once `inflight` + `fifo_count` = `FIFO_DEPTH`, no qm issues beyond that point, and no FIFO overflow.
  - Release `out_ready`: all 20 outputs arrive in order.
- Zero-length: `start` with `num_elems`=0 → `done` two cycles later, no `qm_input_valid` pulse.
- Config lockout: `cfg_we` to ch0 with multiplier 0 during RUN is ignored, and results still use the old entry. The same write in IDLE takes effect for the next tensor.
- Reset mid-operation: assert `rst` during DRAIN with 3 in flight → next cycle state IDLE, `out_valid`=0, `busy`=0, and no stale output afterwards.
